// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Purpose  : Encodings shared by the multicycle control FSM (mc_sequencer),
//             its ALU decoder and the RV32I DataPath: FSM state encoding,
//             opcode constants, mux-select encodings and ALU control codes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    // FSM states. The 4-bit value appears on state_dbg. S_HALT is only
    // reachable when MC_ILLEGAL_TRAP_EN is defined; its code stays reserved
    // otherwise so that state_dbg decoding is identical in both builds.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UI       = 4'd12,
        S_JALWB    = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    // ALU operand B select
    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } ALUsource_t;

    // ALU operand A select
    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } ALUSrcA_t;

    // Result bus select (feeds PC and register file write data)
    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } ResultSource_t;

    // Immediate formats
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } IMM_t;

    // ALU operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_PASSB = 2'b11
    } ALUop_t;

    // ALU control codes understood by the DataPath ALU
    localparam logic [3:0] c_alu_add   = 4'h0;
    localparam logic [3:0] c_alu_sub   = 4'h1;
    localparam logic [3:0] c_alu_and   = 4'h2;
    localparam logic [3:0] c_alu_or    = 4'h3;
    localparam logic [3:0] c_alu_xor   = 4'h4;
    localparam logic [3:0] c_alu_slt   = 4'h5;
    localparam logic [3:0] c_alu_sltu  = 4'h6;
    localparam logic [3:0] c_alu_sll   = 4'h7;
    localparam logic [3:0] c_alu_srl   = 4'h8;
    localparam logic [3:0] c_alu_sra   = 4'h9;
    localparam logic [3:0] c_alu_passb = 4'hA;

endpackage : core_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational ALU control decode. Maps an operation class
//             (add / sub / funct / passB) plus funct3/funct7b5 to alu_ctrl.
//  Ports    : alu_op   - operation class from the control FSM
//             funct3   - instr[14:12]
//             funct7b5 - instr[30]; the caller masks it for I-type ops
//                        other than SRAI so ADDI never turns into SUB
//             alu_ctrl - ALU operation code
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
    import core_pkg::*;
(
    input  ALUop_t      alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [3:0]  alu_ctrl
);

    always_comb begin
        alu_ctrl = c_alu_add;
        case (alu_op)
            ALUOP_ADD:   alu_ctrl = c_alu_add;
            ALUOP_SUB:   alu_ctrl = c_alu_sub;
            ALUOP_PASSB: alu_ctrl = c_alu_passb;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = funct7b5 ? c_alu_sub : c_alu_add;
                    3'b001:  alu_ctrl = c_alu_sll;
                    3'b010:  alu_ctrl = c_alu_slt;
                    3'b011:  alu_ctrl = c_alu_sltu;
                    3'b100:  alu_ctrl = c_alu_xor;
                    3'b101:  alu_ctrl = funct7b5 ? c_alu_sra : c_alu_srl;
                    3'b110:  alu_ctrl = c_alu_or;
                    default: alu_ctrl = c_alu_and;
                endcase
            end
            default:     alu_ctrl = c_alu_add;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mc_sequencer
//  Purpose  : Multicycle control FSM for the RV32I core. Sequences a shared
//             instruction/data memory (with mem_ready handshake), the IR,
//             register file, ALU and PC through fetch/decode/execute/
//             memory/writeback states.
//  Config   : MC_ILLEGAL_TRAP_EN - when defined, unknown opcodes and
//             unsupported branch funct3 values park the FSM in S_HALT and
//             the extra output 'illegal' is present.
//  Params   : RESET_STATE - state loaded by rst (S_FETCH)
//             WAIT_MAX    - max mem_ready wait cycles before timeout; 0 = off
//  Ports    : clk, rst (sync, active-high)
//             opcode/funct3/funct7b5 - fields of the instruction register
//             zero      - ALU zero flag
//             mem_ready - memory completes the current access this cycle
//             mem_req, adr_src, mem_write - memory interface controls
//             ir_write, pc_write, reg_write - datapath enables
//             alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl - selects
//             timeout   - sticky mem_ready wait overflow flag
//             illegal   - (MC_ILLEGAL_TRAP_EN only) FSM is halted
//             state_dbg - current state encoding
//  Revision : 1.0 - initial release
// ============================================================================
module mc_sequencer
    import core_pkg::*;
#(
    parameter state_t      RESET_STATE = S_FETCH,
    parameter int unsigned WAIT_MAX    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic        timeout,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [3:0]  state_dbg
);

    // Where unsupported encodings go: trap or silently fall back to fetch.
`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t c_bad_next = S_HALT;
`else
    localparam state_t c_bad_next = S_FETCH;
`endif

    state_t        r_state;
    state_t        w_next;

    logic          w_mem_req;
    logic          w_adr_src;
    logic          w_mem_write;
    logic          w_ir_write;
    logic          w_pc_write;
    logic          w_reg_write;
    ALUSrcA_t      w_src_a;
    ALUsource_t    w_src_b;
    ResultSource_t w_res_src;
    IMM_t          w_imm_src;
    ALUop_t        w_alu_op;
    logic          w_funct7b5;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore decode. pc_write/ir_write are the only outputs
    // qualified by inputs (mem_ready in FETCH, zero in BRANCH).
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_adr_src   = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        w_src_a     = SRCA_PC;
        w_src_b     = SRCB_RS2;
        w_res_src   = RES_ALUOUT;
        w_imm_src   = IMM_I;
        w_alu_op    = ALUOP_ADD;
        w_funct7b5  = funct7b5;

        case (r_state)
            S_FETCH: begin
                // PC+4 goes straight from the ALU to the PC as the IR loads
                w_mem_req = 1'b1;
                w_src_b   = SRCB_FOUR;
                w_res_src = RES_ALURESULT;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculative branch/jump target OldPC+imm into ALUOut
                w_src_a   = SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_imm_src = (opcode == c_op_jal) ? IMM_J : IMM_B;
                case (opcode)
                    c_op_load,
                    c_op_store:  w_next = S_MEMADR;
                    c_op_rtype:  w_next = S_EXECR;
                    c_op_itype:  w_next = S_EXECI;
                    c_op_branch: w_next = S_BRANCH;
                    c_op_jal:    w_next = S_JAL;
                    c_op_jalr:   w_next = S_JALR;
                    c_op_lui,
                    c_op_auipc:  w_next = S_UI;
                    default:     w_next = c_bad_next;
                endcase
            end

            S_MEMADR: begin
                // opcode[5] separates store (0100011) from load (0000011)
                w_src_a   = SRCA_RS1;
                w_src_b   = SRCB_IMM;
                w_imm_src = opcode[5] ? IMM_S : IMM_I;
                w_next    = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end

            S_MEMWB: begin
                w_res_src   = RES_DATA;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end

            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end

            S_EXECR: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_RS2;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end

            S_EXECI: begin
                // instr[30] is immediate data for I-type except SRAI
                w_src_a    = SRCA_RS1;
                w_src_b    = SRCB_IMM;
                w_alu_op   = ALUOP_FUNCT;
                w_funct7b5 = funct7b5 & (funct3 == 3'b101);
                w_next     = S_ALUWB;
            end

            S_ALUWB: begin
                w_res_src   = RES_ALUOUT;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end

            S_BRANCH: begin
                w_src_a   = SRCA_RS1;
                w_src_b   = SRCB_RS2;
                w_alu_op  = ALUOP_SUB;
                w_imm_src = IMM_B;
                w_res_src = RES_ALUOUT;
                w_next    = S_FETCH;
                case (funct3)
                    3'b000:  w_pc_write = zero;
                    3'b001:  w_pc_write = ~zero;
                    default: w_next     = c_bad_next;
                endcase
            end

            S_JAL, S_JALWB: begin
                // Redirect PC to the target held in ALUOut while the ALU
                // forms the link address OldPC+4 for the following ALUWB.
                w_pc_write = 1'b1;
                w_res_src  = RES_ALUOUT;
                w_src_a    = SRCA_OLDPC;
                w_src_b    = SRCB_FOUR;
                w_next     = S_ALUWB;
            end

            S_JALR: begin
                w_src_a   = SRCA_RS1;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_I;
                w_next    = S_JALWB;
            end

            S_UI: begin
                // opcode[5] separates LUI (0110111) from AUIPC (0010111)
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_U;
                if (opcode[5]) begin
                    w_src_a  = SRCA_PC;
                    w_alu_op = ALUOP_PASSB;
                end else begin
                    w_src_a  = SRCA_OLDPC;
                    w_alu_op = ALUOP_ADD;
                end
                w_next = S_ALUWB;
            end

            S_HALT: begin
                w_next = S_HALT;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset cycle: nothing may be enabled and every select reads zero,
        // whatever state the register currently holds.
        if (rst) begin
            w_mem_req   = 1'b0;
            w_adr_src   = 1'b0;
            w_mem_write = 1'b0;
            w_ir_write  = 1'b0;
            w_pc_write  = 1'b0;
            w_reg_write = 1'b0;
            w_src_a     = SRCA_PC;
            w_src_b     = SRCB_RS2;
            w_res_src   = RES_ALUOUT;
            w_imm_src   = IMM_I;
            w_alu_op    = ALUOP_ADD;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op   (w_alu_op),
        .funct3   (funct3),
        .funct7b5 (w_funct7b5),
        .alu_ctrl (alu_ctrl)
    );

    // ------------------------------------------------------------------
    // mem_ready wait watchdog
    // ------------------------------------------------------------------
    generate
        if (WAIT_MAX > 0) begin : g_timeout
            localparam int c_cnt_w = $clog2(WAIT_MAX + 1);

            logic [c_cnt_w-1:0] r_wait_cnt;
            logic               r_timeout;
            logic               w_waiting;

            assign w_waiting = ((r_state == S_FETCH)   ||
                                (r_state == S_MEMREAD) ||
                                (r_state == S_MEMWRITE)) && !mem_ready;

            // r_wait_cnt holds the number of low cycles already seen; the
            // flag sets on the first low cycle beyond WAIT_MAX.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wait_cnt <= '0;
                    r_timeout  <= 1'b0;
                end else if (w_waiting) begin
                    if (r_wait_cnt == c_cnt_w'(WAIT_MAX)) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end else begin
                    r_wait_cnt <= '0;
                end
            end

            assign timeout = r_timeout;
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign mem_req    = w_mem_req;
    assign adr_src    = w_adr_src;
    assign mem_write  = w_mem_write;
    assign ir_write   = w_ir_write;
    assign pc_write   = w_pc_write;
    assign reg_write  = w_reg_write;
    assign alu_src_a  = w_src_a;
    assign alu_src_b  = w_src_b;
    assign result_src = w_res_src;
    assign imm_src    = w_imm_src;
    assign state_dbg  = r_state;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = (r_state == S_HALT) && !rst;
`endif

endmodule : mc_sequencer
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_sequencer
//  Purpose  : Self-checking bench for mc_sequencer. A table of per-cycle
//             {inputs, expected outputs} records walks the FSM through
//             each instruction class; hand-written sequences cover reset,
//             the mem_ready watchdog, mid-instruction reset and the
//             illegal-encoding handling (both builds of MC_ILLEGAL_TRAP_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_sequencer;

    localparam logic [6:0] c_r    = 7'h33;
    localparam logic [6:0] c_i    = 7'h13;
    localparam logic [6:0] c_ld   = 7'h03;
    localparam logic [6:0] c_st   = 7'h23;
    localparam logic [6:0] c_br   = 7'h63;
    localparam logic [6:0] c_jal  = 7'h6F;
    localparam logic [6:0] c_jalr = 7'h67;
    localparam logic [6:0] c_lui  = 7'h37;
    localparam logic [6:0] c_aui  = 7'h17;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic        timeout;
    logic [3:0]  state_dbg;
`ifdef MC_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    always #5 clk = ~clk;

    mc_sequencer #(.WAIT_MAX(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alu_ctrl   (alu_ctrl),
        .timeout    (timeout),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .state_dbg  (state_dbg)
    );

    // {state, mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
    //  alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl}
    logic [22:0] obs;
    assign obs = {state_dbg, mem_req, adr_src, mem_write, ir_write, pc_write,
                  reg_write, alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl};

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        mr;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fl = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write}
    task automatic row(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic [5:0] fl, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] rs, input logic [2:0] imm, input logic [3:0] ctrl);
        vec_t r;
        r.op = op; r.f3 = f3; r.f7 = f7; r.z = z; r.mr = mr;
        r.exp = {st, fl, a, b, rs, imm, ctrl};
        tbl.push_back(r);
    endtask

    task automatic fetch_row(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input logic mr);
        row(op, f3, f7, z, mr, 4'd0, mr ? 6'b100110 : 6'b100000,
            2'b00, 2'b10, 2'b10, 3'b000, 4'h0);
    endtask

    task automatic decode_row(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic z, input logic [2:0] imm);
        row(op, f3, f7, z, 1'b1, 4'd1, 6'b000000, 2'b01, 2'b01, 2'b00, imm, 4'h0);
    endtask

    task automatic aluwb_row(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z);
        row(op, f3, f7, z, 1'b1, 4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
    endtask

    initial begin
        // ---------------- table -------------------------------------
        // add x3,x1,x2 with two extra fetch wait cycles
        fetch_row(c_r, 3'd0, 1'b0, 1'b0, 1'b0);
        fetch_row(c_r, 3'd0, 1'b0, 1'b0, 1'b0);
        fetch_row(c_r, 3'd0, 1'b0, 1'b0, 1'b1);
        decode_row(c_r, 3'd0, 1'b0, 1'b0, 3'b010);
        row(c_r, 3'd0, 1'b0, 1'b0, 1'b1, 4'd6, 6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 4'h0);
        aluwb_row(c_r, 3'd0, 1'b0, 1'b0);
        // sub
        fetch_row(c_r, 3'd0, 1'b1, 1'b0, 1'b1);
        decode_row(c_r, 3'd0, 1'b1, 1'b0, 3'b010);
        row(c_r, 3'd0, 1'b1, 1'b0, 1'b1, 4'd6, 6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 4'h1);
        aluwb_row(c_r, 3'd0, 1'b1, 1'b0);
        // srl (R-type, funct7b5=0)
        fetch_row(c_r, 3'd5, 1'b0, 1'b0, 1'b1);
        decode_row(c_r, 3'd5, 1'b0, 1'b0, 3'b010);
        row(c_r, 3'd5, 1'b0, 1'b0, 1'b1, 4'd6, 6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 4'h8);
        aluwb_row(c_r, 3'd5, 1'b0, 1'b0);
        // srai
        fetch_row(c_i, 3'd5, 1'b1, 1'b0, 1'b1);
        decode_row(c_i, 3'd5, 1'b1, 1'b0, 3'b010);
        row(c_i, 3'd5, 1'b1, 1'b0, 1'b1, 4'd7, 6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'h9);
        aluwb_row(c_i, 3'd5, 1'b1, 1'b0);
        // addi with instr[30]=1 must stay ADD
        fetch_row(c_i, 3'd0, 1'b1, 1'b0, 1'b1);
        decode_row(c_i, 3'd0, 1'b1, 1'b0, 3'b010);
        row(c_i, 3'd0, 1'b1, 1'b0, 1'b1, 4'd7, 6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'h0);
        aluwb_row(c_i, 3'd0, 1'b1, 1'b0);
        // xori
        fetch_row(c_i, 3'd4, 1'b0, 1'b0, 1'b1);
        decode_row(c_i, 3'd4, 1'b0, 1'b0, 3'b010);
        row(c_i, 3'd4, 1'b0, 1'b0, 1'b1, 4'd7, 6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'h4);
        aluwb_row(c_i, 3'd4, 1'b0, 1'b0);
        // beq zero=1 -> taken
        fetch_row(c_br, 3'd0, 1'b0, 1'b1, 1'b1);
        decode_row(c_br, 3'd0, 1'b0, 1'b1, 3'b010);
        row(c_br, 3'd0, 1'b0, 1'b1, 1'b1, 4'd9, 6'b000010, 2'b10, 2'b00, 2'b00, 3'b010, 4'h1);
        // bne zero=1 -> not taken
        fetch_row(c_br, 3'd1, 1'b0, 1'b1, 1'b1);
        decode_row(c_br, 3'd1, 1'b0, 1'b1, 3'b010);
        row(c_br, 3'd1, 1'b0, 1'b1, 1'b1, 4'd9, 6'b000000, 2'b10, 2'b00, 2'b00, 3'b010, 4'h1);
        // bne zero=0 -> taken
        fetch_row(c_br, 3'd1, 1'b0, 1'b0, 1'b1);
        decode_row(c_br, 3'd1, 1'b0, 1'b0, 3'b010);
        row(c_br, 3'd1, 1'b0, 1'b0, 1'b1, 4'd9, 6'b000010, 2'b10, 2'b00, 2'b00, 3'b010, 4'h1);
        // sw x2,0(x1) with one memory wait cycle
        fetch_row(c_st, 3'd2, 1'b0, 1'b0, 1'b1);
        decode_row(c_st, 3'd2, 1'b0, 1'b0, 3'b010);
        row(c_st, 3'd2, 1'b0, 1'b0, 1'b1, 4'd2, 6'b000000, 2'b10, 2'b01, 2'b00, 3'b001, 4'h0);
        row(c_st, 3'd2, 1'b0, 1'b0, 1'b0, 4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
        row(c_st, 3'd2, 1'b0, 1'b0, 1'b1, 4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
        // lw with three wait cycles in MEMREAD (8 cycles total)
        fetch_row(c_ld, 3'd2, 1'b0, 1'b0, 1'b1);
        decode_row(c_ld, 3'd2, 1'b0, 1'b0, 3'b010);
        row(c_ld, 3'd2, 1'b0, 1'b0, 1'b1, 4'd2, 6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'h0);
        row(c_ld, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3, 6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
        row(c_ld, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3, 6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
        row(c_ld, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3, 6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
        row(c_ld, 3'd2, 1'b0, 1'b0, 1'b1, 4'd3, 6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
        row(c_ld, 3'd2, 1'b0, 1'b0, 1'b1, 4'd4, 6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 4'h0);
        // jal
        fetch_row(c_jal, 3'd0, 1'b0, 1'b0, 1'b1);
        decode_row(c_jal, 3'd0, 1'b0, 1'b0, 3'b100);
        row(c_jal, 3'd0, 1'b0, 1'b0, 1'b1, 4'd10, 6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 4'h0);
        aluwb_row(c_jal, 3'd0, 1'b0, 1'b0);
        // jalr
        fetch_row(c_jalr, 3'd0, 1'b0, 1'b0, 1'b1);
        decode_row(c_jalr, 3'd0, 1'b0, 1'b0, 3'b010);
        row(c_jalr, 3'd0, 1'b0, 1'b0, 1'b1, 4'd11, 6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'h0);
        row(c_jalr, 3'd0, 1'b0, 1'b0, 1'b1, 4'd13, 6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 4'h0);
        aluwb_row(c_jalr, 3'd0, 1'b0, 1'b0);
        // lui
        fetch_row(c_lui, 3'd0, 1'b0, 1'b0, 1'b1);
        decode_row(c_lui, 3'd0, 1'b0, 1'b0, 3'b010);
        row(c_lui, 3'd0, 1'b0, 1'b0, 1'b1, 4'd12, 6'b000000, 2'b00, 2'b01, 2'b00, 3'b011, 4'hA);
        aluwb_row(c_lui, 3'd0, 1'b0, 1'b0);
        // auipc
        fetch_row(c_aui, 3'd0, 1'b0, 1'b0, 1'b1);
        decode_row(c_aui, 3'd0, 1'b0, 1'b0, 3'b010);
        row(c_aui, 3'd0, 1'b0, 1'b0, 1'b1, 4'd12, 6'b000000, 2'b01, 2'b01, 2'b00, 3'b011, 4'h0);
        aluwb_row(c_aui, 3'd0, 1'b0, 1'b0);

        // ---------------- reset -------------------------------------
        rst = 1'b1; opcode = c_r; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_outputs_c1", {13'd0, obs[18:0]}, 32'd0);
        tick();
        @(negedge clk);
        chk("rst_outputs_c2", {13'd0, obs[18:0]}, 32'd0);
        chk("rst_state", {28'd0, state_dbg}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", {9'd0, obs},
            {9'd0, 4'd0, 6'b100000, 2'b00, 2'b10, 2'b10, 3'b000, 4'h0});
        tick();

        // ---------------- table walk --------------------------------
        for (int i = 0; i < tbl.size(); i++) begin
            opcode    = tbl[i].op;
            funct3    = tbl[i].f3;
            funct7b5  = tbl[i].f7;
            zero      = tbl[i].z;
            mem_ready = tbl[i].mr;
            @(negedge clk);
            total++;
            if (obs !== tbl[i].exp) begin
                bad++;
                $display("FAIL vec%0d: got %06h expected %06h", i, obs, tbl[i].exp);
            end
            tick();
        end
        chk("timeout_idle", {31'd0, timeout}, 32'd0);
        chk("table_end_fetch", {28'd0, state_dbg}, 32'd0);

        // ---------------- watchdog boundary -------------------------
        opcode = c_ld; funct3 = 3'd2; zero = 1'b0;
        mem_ready = 1'b0;
        repeat (3) tick();
        chk("timeout_at_max", {31'd0, timeout}, 32'd0);
        tick();
        chk("timeout_over_max", {31'd0, timeout}, 32'd1);
        chk("timeout_holds_fetch", {28'd0, state_dbg}, 32'd0);
        mem_ready = 1'b1;
        repeat (4) tick();   // DECODE, MEMADR, MEMREAD, MEMWB
        chk("lw_at_memwb", {28'd0, state_dbg}, 32'd4);
        chk("timeout_sticky", {31'd0, timeout}, 32'd1);

        // ---------------- reset mid-instruction ---------------------
        rst = 1'b1;
        #1;
        chk("mid_rst_regwrite", {31'd0, reg_write}, 32'd0);
        chk("mid_rst_state_held", {28'd0, state_dbg}, 32'd4);
        tick();
        chk("mid_rst_to_fetch", {28'd0, state_dbg}, 32'd0);
        chk("mid_rst_clr_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0;

        // ---------------- unknown opcode 0x7F -----------------------
        opcode = 7'h7F; funct3 = 3'd0; mem_ready = 1'b1;
        tick();
        tick();
`ifdef MC_ILLEGAL_TRAP_EN
        chk("bad_op_halt", {28'd0, state_dbg}, 32'd14);
        repeat (3) tick();
        @(negedge clk);
        chk("halt_stays", {28'd0, state_dbg}, 32'd14);
        chk("halt_illegal", {31'd0, illegal}, 32'd1);
        chk("halt_enables", {26'd0, obs[18:13]}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt_rst_exit", {28'd0, state_dbg}, 32'd0);
        chk("halt_rst_illegal", {31'd0, illegal}, 32'd0);
`else
        chk("bad_op_nop", {28'd0, state_dbg}, 32'd0);
`endif

        // ---------------- unsupported branch funct3 (bge) -----------
        opcode = c_br; funct3 = 3'd5; zero = 1'b1; mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("bge_state", {28'd0, state_dbg}, 32'd9);
        chk("bge_no_pcwrite", {31'd0, pc_write}, 32'd0);
        tick();
`ifdef MC_ILLEGAL_TRAP_EN
        chk("bge_halt", {28'd0, state_dbg}, 32'd14);
`else
        chk("bge_nop", {28'd0, state_dbg}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mc_sequencer
`default_nettype wire

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multicycle control FSM for the RV32I core. It replaces the single-cycle control path and sequences one shared instruction/data memory, the instruction register, the register file, the ALU and the PC through fetch/decode/execute/memory/writeback states. It sits between the DataPath and the unified memory. It adds a memory ready handshake so memory latency can be variable.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset.
- WAIT_MAX, 0, cycles the block may wait for mem_ready before flagging a timeout; 0 disables the check.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] taken from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  store strobe, valid only together with mem_req
- ir_write  out  1  load the instruction register and OldPC
- pc_write  out  1  PC enable
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- imm_src  out  3  immediate format: I, S, B, U, J
- alu_ctrl  out  4  ALU operation
- timeout  out  1  sticky flag: mem_ready wait exceeded WAIT_MAX
- state_dbg  out  4  current state encoding

Behaviour:
- Reset and output style
  - clk is the only clock. rst is synchronous and active-high.
  - rst loads state=S_FETCH and clears timeout.
  - While rst=1, all enables are 0: mem_req, mem_write, ir_write, pc_write, reg_write. All selects are 0.
  - Outputs are Moore decodes of the state. The exceptions are pc_write and ir_write, which are qualified by mem_ready or zero as stated below.
- FETCH
  - Drives mem_req=1, adr_src=0, alu_src_a=PC, alu_src_b=4, alu add, result_src=10.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
  - When mem_ready=0: hold FETCH with ir_write=0 and pc_write=0.
- DECODE
  - Computes OldPC+imm (B-type imm) into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 or 0010111 → UI
    - any other opcode → FETCH (NOP)
- MEMADR: rs1+imm (I or S format) → ALUOut. Next MEMREAD for a load, MEMWRITE for a store.
- MEMREAD
  - mem_req=1, adr_src=1.
  - Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, next FETCH.
- MEMWRITE
  - mem_req=1, mem_write=1, adr_src=1.
  - Hold until mem_ready, then go to FETCH.
- EXECR and EXECI
  - alu_src_a=rs1. alu_src_b = rs2 (EXECR) or imm (EXECI).
  - alu_ctrl is decoded from funct3 and funct7b5. funct7b5 is ignored for I-type except for SRAI.
  - Next ALUWB.
- ALUWB: result_src=00, reg_write=1, next FETCH.
- BRANCH
  - Compares rs1 with rs2 using subtraction.
  - pc_write = (funct3=000 & zero) | (funct3=001 & ~zero), with result_src=00 (target).
  - Other funct3 values: not taken.
  - Next FETCH.
- JAL
  - pc_write=1 with result_src=00 (J target). alu computes OldPC+4.
  - Next ALUWB, which writes rd = PC+4.
- JALR: rs1+imm → ALUOut, next JAL-like writeback state JALWB.
  - Open point: the state list above has no JALWB state and the encoding is still to be fixed.
- UI: LUI passes the immediate (alu_src_a=PC, alu_ctrl=pass-B); AUIPC adds OldPC+imm. Next ALUWB.
- Cycle counts with mem_ready=1 on the first request:
  - R/I/JAL/UI: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
- timeout: when WAIT_MAX>0 and mem_ready stays low for more than WAIT_MAX consecutive cycles in FETCH, MEMREAD or MEMWRITE, timeout sets and stays high. The FSM keeps waiting.
- rst in the middle of an instruction aborts it. No write enable asserts in the reset cycle.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - Adds state S_HALT and output illegal (1 bit).
  - An unknown opcode in DECODE, or branch funct3 not in {000, 001}, moves the FSM to S_HALT.
  - In S_HALT, illegal=1 and all enables are 0. Only rst leaves S_HALT.
- Undefined: these cases act as a NOP and return to FETCH. The illegal port is absent.

Decomposition:
- Shared package (core_pkg):
  - state_t enum
  - opcode constants
  - ALUsource_t, ALUSrcA_t, ResultSource_t, IMM_t and ALUop_t encodings, shared with DataPath
- Sub-module alu_decoder (combinational): takes an alu_op class (add / sub / funct / passB) plus funct3 and funct7b5, and produces alu_ctrl.

Test Plan:
1. rst=1 for 2 cycles, then release → state_dbg=FETCH, mem_req=1, all write enables 0 during reset.
2. add x3,x1,x2 (0x002081B3) with mem_ready=1 → FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in cycle 4, result_src=00.
3. lw with mem_ready low for 3 cycles in MEMREAD → FSM holds MEMREAD with adr_src=1; MEMWB follows in the cycle after mem_ready; 8 cycles total.
4. beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for beq, 0 for bne; each takes 3 cycles.
5. sw (0x0020A023) → mem_write=1 only in MEMWRITE; reg_write is never 1.
6. Opcode 0x7F: without MC_ILLEGAL_TRAP_EN → back in FETCH after 2 cycles; with it → S_HALT, illegal=1, and the FSM stays there until rst.
